// File: rtl/adaptive_threshold_pkg.sv
// Shared constants and the pixel record used by the result write arbiter and its lane FIFOs.
// One package covers the whole adaptive-threshold pipeline, so the lane/coordinate widths are defined in one place.
package adaptive_threshold_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_BITS  = 2;
    localparam int COL_BITS   = 8;
    localparam int ROW_BITS   = 8;
    localparam int FIFO_BITS  = 2;
    localparam int FIFO_DEPTH = 1 << FIFO_BITS;
    localparam int PIX_W      = ROW_BITS + COL_BITS + 1;

    // Field order matches the packed {row, col, data} word held in each lane FIFO.
    typedef struct packed {
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic                data;
    } pixel_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO holding pixel records, with a sticky flag for pushes refused while full.
module lane_fifo
    import adaptive_threshold_pkg::*;
(
    input  logic             clock,
    input  logic             not_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam logic [FIFO_BITS:0] COUNT_FULL = {1'b1, {FIFO_BITS{1'b0}}};

    logic [PIX_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_BITS-1:0] r_wr_ptr;
    logic [FIFO_BITS-1:0] r_rd_ptr;
    logic [FIFO_BITS:0]   r_count;
    logic                 r_overflow;
    logic                 w_wr_en;
    logic                 w_rd_en;

    // full/empty come straight from the count register, so ready has no path from push.
    assign full     = (r_count == COUNT_FULL);
    assign empty    = (r_count == '0);
    assign overflow = r_overflow;
    assign w_wr_en  = push & ~full;
    assign w_rd_en  = pop & ~empty;
    assign dout     = r_mem[r_rd_ptr];

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so push and pop
    // in the same edge both see the old count and pointers.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (push && full) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale entries
    // are never observed and the array can map onto plain RAM/flops without reset muxes.
    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Merges the box_filter lane pixel streams onto the single display write port through per-lane
// FIFOs and a rotating-priority arbiter that drains one pixel per clock.
module result_write_arbiter
    import adaptive_threshold_pkg::*;
(
    input  logic                          clock,
    input  logic                          not_reset,
    input  logic [NUM_LANES-1:0]          iLaneValid,
    input  logic [NUM_LANES*COL_BITS-1:0] iLaneCol,
    input  logic [NUM_LANES*ROW_BITS-1:0] iLaneRow,
    input  logic [NUM_LANES-1:0]          iLaneData,
    output logic [NUM_LANES-1:0]          oLaneReady,
    output logic [ROW_BITS-1:0]           oX,
    output logic [COL_BITS-1:0]           oY,
    output logic [2:0]                    oR,
    output logic [2:0]                    oG,
    output logic [2:0]                    oB,
    output logic                          oWren,
    output logic [NUM_LANES-1:0]          oOverflow,
    output logic                          oIdle
);

    pixel_t               w_din  [NUM_LANES];
    pixel_t               w_dout [NUM_LANES];
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_pop;
    logic                 w_grant_valid;
    logic [LANE_BITS-1:0] w_grant_lane;
    pixel_t               w_sel;

    logic [LANE_BITS-1:0] r_rr;
    logic                 r_wren;
    logic [ROW_BITS-1:0]  r_x;
    logic [COL_BITS-1:0]  r_y;
    logic                 r_data;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign w_din[i] = {iLaneRow[i*ROW_BITS +: ROW_BITS],
                           iLaneCol[i*COL_BITS +: COL_BITS],
                           iLaneData[i]};
        assign w_pop[i] = w_grant_valid && (w_grant_lane == LANE_BITS'(i));

        lane_fifo u_fifo (
            .clock     (clock),
            .not_reset (not_reset),
            .push      (iLaneValid[i]),
            .pop       (w_pop[i]),
            .din       (w_din[i]),
            .dout      (w_dout[i]),
            .full      (w_full[i]),
            .empty     (w_empty[i]),
            .overflow  (oOverflow[i])
        );
    end

    // Rotating priority: scan from r_rr upward; lane indices wrap naturally in LANE_BITS.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin : grant_search
        logic [LANE_BITS-1:0] idx;
        w_grant_valid = 1'b0;
        w_grant_lane  = '0;
        idx           = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = r_rr + LANE_BITS'(k);
            if (!w_grant_valid && !w_empty[idx]) begin
                w_grant_valid = 1'b1;
                w_grant_lane  = idx;
            end
        end
    end

    assign w_sel = w_dout[w_grant_lane];

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_rr   <= '0;
            r_wren <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_data <= 1'b0;
        end else begin
            r_wren <= w_grant_valid;
            if (w_grant_valid) begin
                r_x    <= w_sel.row;
                r_y    <= w_sel.col;
                r_data <= w_sel.data;
                r_rr   <= w_grant_lane + LANE_BITS'(1);
            end
        end
    end

    // The display is transposed: pixel row drives X, pixel column drives Y.
    assign oX         = r_x;
    assign oY         = r_y;
    assign oR         = {3{r_data}};
    assign oG         = {3{r_data}};
    assign oB         = {3{r_data}};
    assign oWren      = r_wren;
    assign oLaneReady = ~w_full;
    assign oIdle      = (&w_empty) & ~r_wren;

endmodule

// File: tb/tb_result_write_arbiter.sv
// Self-checking bench for result_write_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_result_write_arbiter;
    import adaptive_threshold_pkg::*;

    logic                          clock = 1'b0;
    logic                          not_reset = 1'b0;
    logic [NUM_LANES-1:0]          iLaneValid = '0;
    logic [NUM_LANES*COL_BITS-1:0] iLaneCol = '0;
    logic [NUM_LANES*ROW_BITS-1:0] iLaneRow = '0;
    logic [NUM_LANES-1:0]          iLaneData = '0;
    logic [NUM_LANES-1:0]          oLaneReady;
    logic [ROW_BITS-1:0]           oX;
    logic [COL_BITS-1:0]           oY;
    logic [2:0]                    oR, oG, oB;
    logic                          oWren;
    logic [NUM_LANES-1:0]          oOverflow;
    logic                          oIdle;

    result_write_arbiter dut (
        .clock      (clock),
        .not_reset  (not_reset),
        .iLaneValid (iLaneValid),
        .iLaneCol   (iLaneCol),
        .iLaneRow   (iLaneRow),
        .iLaneData  (iLaneData),
        .oLaneReady (oLaneReady),
        .oX         (oX),
        .oY         (oY),
        .oR         (oR),
        .oG         (oG),
        .oB         (oB),
        .oWren      (oWren),
        .oOverflow  (oOverflow),
        .oIdle      (oIdle)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per lane, round-robin pointer as a plain integer.
    logic [PIX_W-1:0]     mq [NUM_LANES][$];
    int                   m_rr   = 0;
    logic                 m_wren = 1'b0;
    logic [ROW_BITS-1:0]  m_x    = '0;
    logic [COL_BITS-1:0]  m_y    = '0;
    logic                 m_d    = 1'b0;
    logic [NUM_LANES-1:0] m_ovf  = '0;

    always @(posedge clock or negedge not_reset) begin : model
        int sz [NUM_LANES];
        int g;
        bit found;
        logic [PIX_W-1:0] p;
        if (!not_reset) begin
            for (int l = 0; l < NUM_LANES; l++) mq[l].delete();
            m_rr = 0; m_wren = 1'b0; m_x = '0; m_y = '0; m_d = 1'b0; m_ovf = '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) sz[l] = mq[l].size();
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (!found && sz[(m_rr + k) % NUM_LANES] > 0) begin
                    found = 1'b1;
                    g = (m_rr + k) % NUM_LANES;
                end
            end
            if (found) begin
                p = mq[g].pop_front();
                m_x = p[PIX_W-1 -: ROW_BITS];
                m_y = p[COL_BITS:1];
                m_d = p[0];
                m_wren = 1'b1;
                m_rr = (g + 1) % NUM_LANES;
            end else begin
                m_wren = 1'b0;
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                if (iLaneValid[l]) begin
                    if (sz[l] < FIFO_DEPTH)
                        mq[l].push_back({iLaneRow[l*ROW_BITS +: ROW_BITS],
                                         iLaneCol[l*COL_BITS +: COL_BITS], iLaneData[l]});
                    else
                        m_ovf[l] = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [NUM_LANES-1:0] er;
        logic ei;
        if (chk_en) begin
            ei = !m_wren;
            for (int l = 0; l < NUM_LANES; l++) begin
                er[l] = (mq[l].size() < FIFO_DEPTH);
                if (mq[l].size() != 0) ei = 1'b0;
            end
            check("cyc_wren",  32'(oWren),              32'(m_wren));
            check("cyc_x",     32'(oX),                 32'(m_x));
            check("cyc_y",     32'(oY),                 32'(m_y));
            check("cyc_rgb",   32'({oR, oG, oB}),       32'({9{m_d}}));
            check("cyc_ready", 32'(oLaneReady),         32'(er));
            check("cyc_ovf",   32'(oOverflow),          32'(m_ovf));
            check("cyc_idle",  32'(oIdle),              32'(ei));
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [ROW_BITS-1:0] row,
                            input logic [COL_BITS-1:0] col, input logic d);
        iLaneValid[l] = 1'b1;
        iLaneRow[l*ROW_BITS +: ROW_BITS] = row;
        iLaneCol[l*COL_BITS +: COL_BITS] = col;
        iLaneData[l] = d;
    endtask

    task automatic do_reset();
        iLaneValid = '0;
        not_reset = 1'b0;
        tick();
        tick();
        not_reset = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int emit, last0, viol, c0, c3, last_lane;
        bit honor;
        tick();
        tick();

        // Reset state
        check("rst_wren",  32'(oWren), 32'd0);
        check("rst_x",     32'(oX), 32'd0);
        check("rst_y",     32'(oY), 32'd0);
        check("rst_rgb",   32'({oR, oG, oB}), 32'd0);
        check("rst_ready", 32'(oLaneReady), 32'hF);
        check("rst_ovf",   32'(oOverflow), 32'd0);
        check("rst_idle",  32'(oIdle), 32'd1);
        chk_en = 1'b1;
        not_reset = 1'b1;
        tick();

        // Single lane, two-clock latency
        set_lane(2, 8'd5, 8'd9, 1'b1);
        tick();
        iLaneValid = '0;
        check("single_early", 32'(oWren), 32'd0);
        tick();
        check("single_wren", 32'(oWren), 32'd1);
        check("single_x",    32'(oX), 32'd5);
        check("single_y",    32'(oY), 32'd9);
        check("single_r",    32'(oR), 32'h7);
        check("model_x",     32'(m_x), 32'd5);
        tick();
        check("single_done", 32'(oWren), 32'd0);
        check("single_idle", 32'(oIdle), 32'd1);

        // Collision from rr=0: lanes served 0,1,2,3
        do_reset();
        for (int l = 0; l < NUM_LANES; l++) set_lane(l, 8'(10 + l), 8'(20 + l), l[0]);
        tick();
        iLaneValid = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            tick();
            check("coll_wren", 32'(oWren), 32'd1);
            check("coll_x",    32'(oX), 32'(10 + l));
            check("coll_y",    32'(oY), 32'(20 + l));
            check("model_coll", 32'(m_x), 32'(10 + l));
        end
        tick();
        check("coll_done", 32'(oWren), 32'd0);
        check("coll_idle", 32'(oIdle), 32'd1);

        // Fairness: lanes 0 and 3 push whenever ready
        viol = 0; c0 = 0; c3 = 0; last_lane = -1;
        for (int i = 0; i < 40; i++) begin
            iLaneValid = '0;
            if (oLaneReady[0]) set_lane(0, {2'd0, 6'(i)}, 8'(i), 1'b0);
            if (oLaneReady[3]) set_lane(3, {2'd3, 6'(i)}, 8'(i), 1'b1);
            tick();
            if (oWren) begin
                if (int'(oX[7:6]) == last_lane) viol++;
                if (oX[7:6] == 2'd0) c0++;
                else if (oX[7:6] == 2'd3) c3++;
                else viol++;
                last_lane = int'(oX[7:6]);
            end
        end
        iLaneValid = '0;
        check("fair_alternate", 32'(viol), 32'd0);
        check("fair_balance", 32'((c0 > c3 ? c0 - c3 : c3 - c0) <= 1), 32'd1);
        check("fair_active", 32'(c0 + c3 >= 30), 32'd1);
        repeat (12) tick();

        // Full/overflow with rr=1 so lane 0 is served last and fills first
        do_reset();
        set_lane(0, 8'hFF, 8'hFF, 1'b0);
        tick();
        iLaneValid = '0;
        tick();
        tick();
        emit = 0; last0 = -1;
        for (int j = 0; j < 5; j++) begin
            for (int l = 0; l < NUM_LANES; l++) set_lane(l, {2'(l), 6'(j)}, 8'(j), j[0]);
            tick();
            if (j == 2) check("ovf_ready_before", 32'(oLaneReady[0]), 32'd1);
            if (j == 3) check("ovf_ready_drop",   32'(oLaneReady[0]), 32'd0);
            if (oWren) begin
                emit++;
                if (oX[7:6] == 2'd0) last0 = int'(oX[5:0]);
            end
        end
        iLaneValid = '0;
        for (int j = 0; j < 25; j++) begin
            tick();
            if (oWren) begin
                emit++;
                if (oX[7:6] == 2'd0) last0 = int'(oX[5:0]);
            end
        end
        check("ovf_flags",   32'(oOverflow), 32'h1);
        check("model_ovf",   32'(m_ovf), 32'h1);
        check("ovf_emitted", 32'(emit), 32'd19);
        check("ovf_last0",   32'(last0), 32'd3);
        tick();
        check("ovf_sticky",  32'(oOverflow), 32'h1);

        // Reset mid-operation with pixels queued
        do_reset();
        for (int l = 0; l < NUM_LANES; l++) set_lane(l, 8'(40 + l), 8'(l), 1'b1);
        tick();
        iLaneValid = '0;
        tick();
        check("mid_busy", 32'(oWren), 32'd1);
        not_reset = 1'b0;
        #1;
        check("mid_wren",  32'(oWren), 32'd0);
        check("mid_ready", 32'(oLaneReady), 32'hF);
        check("mid_idle",  32'(oIdle), 32'd1);
        tick();
        not_reset = 1'b1;
        emit = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (oWren) emit++;
        end
        check("mid_no_emit", 32'(emit), 32'd0);

        // Randomized traffic: first half honors ready, second half ignores it
        for (int i = 0; i < 400; i++) begin
            honor = (i < 200);
            iLaneValid = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if ($urandom_range(0, 99) < 55 && (!honor || oLaneReady[l]))
                    set_lane(l, 8'($urandom), 8'($urandom), 1'($urandom));
            end
            tick();
        end
        iLaneValid = '0;
        repeat (30) tick();
        check("final_idle", 32'(oIdle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
